// File: rtl/subsys_boot_seq.sv
// subsys_boot_seq: APB master that reads the fuse word, programs IOMUX and
// walks the subsystem out of reset with a timed hold before enable.
module subsys_boot_seq #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int RST_HOLD   = 16,
    parameter int TIMEOUT    = 64
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [15:0]           fuse_q,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic [DATA_WIDTH-1:0] PWDATA,
    output logic                  PWRITE,
    output logic                  PSEL,
    output logic                  PENABLE,
    input  logic [DATA_WIDTH-1:0] PRDATA,
    input  logic                  PREADY
);
    typedef enum logic [2:0] {IDLE, SETUP, ACCESS, HOLD, DONE, ERR} state_t;

    localparam logic [7:0] HOLD_LAST = 8'(RST_HOLD - 1);
    localparam logic [7:0] TMO_LAST  = 8'(TIMEOUT - 1);

    state_t                state_q, state_d;
    logic [1:0]            op_q, op_d;
    logic [7:0]            tmo_q, tmo_d, hold_q, hold_d;
    logic [15:0]           fuse_d;
    logic                  xfer_d;
    logic [ADDR_WIDTH-1:0] addr_d;
    logic [DATA_WIDTH-1:0] wdata_d;
    logic                  unused_prdata;

    assign unused_prdata = ^PRDATA;

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        tmo_d   = tmo_q;
        hold_d  = hold_q;
        fuse_d  = fuse_q;
        unique case (state_q)
            IDLE, DONE, ERR: begin
                state_d = start ? SETUP : state_q;
                op_d    = start ? 2'd0 : op_q;
            end
            SETUP: state_d = ACCESS;
            ACCESS: begin
                if (PREADY) begin
                    fuse_d  = (op_q == 2'd0) ? PRDATA[15:0] : fuse_q;
                    state_d = (op_q == 2'd2) ? HOLD : (op_q == 2'd3) ? DONE : SETUP;
                    op_d    = op_q + 2'd1;
                    hold_d  = 8'd0;
                end else if (tmo_q == TMO_LAST) begin
                    state_d = ERR;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
            end
            HOLD: begin
                state_d = (hold_q == HOLD_LAST) ? SETUP : HOLD;
                hold_d  = hold_q + 8'd1;
            end
            default: state_d = IDLE;
        endcase
        tmo_d = (state_d == SETUP) ? 8'd0 : tmo_d;
    end

    // APB outputs are registered from the next state so they line up with it.
    assign xfer_d  = (state_d == SETUP) || (state_d == ACCESS);
    assign addr_d  = (op_d == 2'd0) ? ADDR_WIDTH'(12) : (op_d == 2'd1) ? ADDR_WIDTH'(8) : '0;
    assign wdata_d = (op_d == 2'd1) ? DATA_WIDTH'(fuse_d[3:0]) :
                     (op_d == 2'd2) ? DATA_WIDTH'(2) : DATA_WIDTH'(1);

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q <= IDLE;
            op_q    <= 2'd0;
            tmo_q   <= 8'd0;
            hold_q  <= 8'd0;
            fuse_q  <= 16'd0;
            busy    <= 1'b0;
            done    <= 1'b0;
            error   <= 1'b0;
            PSEL    <= 1'b0;
            PENABLE <= 1'b0;
            PWRITE  <= 1'b0;
            PADDR   <= '0;
            PWDATA  <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            tmo_q   <= tmo_d;
            hold_q  <= hold_d;
            fuse_q  <= fuse_d;
            busy    <= xfer_d || (state_d == HOLD);
            done    <= state_d == DONE;
            error   <= state_d == ERR;
            PSEL    <= xfer_d;
            PENABLE <= state_d == ACCESS;
            PWRITE  <= xfer_d && (op_d != 2'd0);
            PADDR   <= xfer_d ? addr_d : '0;
            PWDATA  <= (xfer_d && (op_d != 2'd0)) ? wdata_d : '0;
        end
    end
endmodule

// File: tb/tb_subsys_boot_seq.sv
// tb_subsys_boot_seq: directed checks of the boot sequencer against hand-computed
// cycle counts and APB transfer lists.
module tb_subsys_boot_seq;
    logic        PCLK = 1'b0;
    logic        PRESETn, start, busy, done, error, PWRITE, PSEL, PENABLE, PREADY;
    logic [15:0] fuse_q;
    logic [31:0] PADDR, PWDATA, PRDATA;
    int          checks = 0, failures = 0;
    int          ntx = 0, base, k, acc;
    logic [31:0] tx_addr [0:63];
    logic [31:0] tx_data [0:63];
    logic        tx_wr   [0:63];

    subsys_boot_seq dut (
        .PCLK(PCLK), .PRESETn(PRESETn), .start(start), .busy(busy), .done(done),
        .error(error), .fuse_q(fuse_q), .PADDR(PADDR), .PWDATA(PWDATA),
        .PWRITE(PWRITE), .PSEL(PSEL), .PENABLE(PENABLE), .PRDATA(PRDATA), .PREADY(PREADY)
    );

    always #5 PCLK = ~PCLK;

    always @(posedge PCLK) begin
        if (PSEL && PENABLE && PREADY && ntx < 64) begin
            tx_addr[ntx] <= PADDR;
            tx_data[ntx] <= PWDATA;
            tx_wr[ntx]   <= PWRITE;
            ntx          <= ntx + 1;
        end
    end

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_tx(input string tag, input int i, input logic wr, input logic [31:0] a, input logic [31:0] d);
        chk(tag, {tx_wr[i], tx_addr[i], tx_data[i]}, {wr, a, d});
    endtask

    task automatic pulse_start;
        start = 1'b1;
        @(negedge PCLK);
        start = 1'b0;
    endtask

    task automatic run_until(input int k0, output int kk);
        kk = k0;
        while (!(done || error) && kk < 300) begin
            @(negedge PCLK);
            kk++;
        end
    endtask

    initial begin
        PRESETn = 1'b0; start = 1'b0; PREADY = 1'b1; PRDATA = 32'h0;
        repeat (2) @(negedge PCLK);
        chk("rst_ctrl", {busy, done, error, PSEL, PENABLE, PWRITE}, 6'b0);
        chk("rst_bus", {PADDR, PWDATA, fuse_q}, 80'h0);
        PRESETn = 1'b1;
        repeat (5) @(negedge PCLK);
        chk("no_autoboot", {busy, PSEL, done}, 3'b0);

        // Nominal boot; upper PRDATA bits must be ignored
        PRDATA = 32'hA5A5_BEEF; base = ntx;
        pulse_start();
        chk("t1_setup0", {busy, PSEL, PENABLE, PWRITE, PADDR}, {4'b1100, 32'hC});
        @(negedge PCLK);
        chk("t1_access0", {PSEL, PENABLE, PADDR}, {2'b11, 32'hC});
        @(negedge PCLK);
        chk("t1_setup1", {PSEL, PENABLE, PWRITE, PADDR, PWDATA, fuse_q}, {3'b101, 32'h8, 32'hF, 16'hBEEF});
        repeat (4) @(negedge PCLK);
        chk("t1_hold", {busy, PSEL, PENABLE, PWRITE, PADDR}, {4'b1000, 32'h0});
        run_until(6, k);
        chk("t1_len", k, 24);
        chk("t1_flags", {done, error, busy, fuse_q}, {3'b100, 16'hBEEF});
        chk("t1_ntx", ntx - base, 4);
        chk_tx("t1_tx0", base, 1'b0, 32'hC, 32'h0);
        chk_tx("t1_tx1", base + 1, 1'b1, 32'h8, 32'hF);
        chk_tx("t1_tx2", base + 2, 1'b1, 32'h0, 32'h2);
        chk_tx("t1_tx3", base + 3, 1'b1, 32'h0, 32'h1);

        // Wait states in op 1 plus ignored starts at cycles 3 and 10
        PRDATA = 32'h3; base = ntx;
        pulse_start();
        chk("t2_accept", {done, busy}, 2'b01);
        k = 0;
        while (!(done || error) && k < 300) begin
            start  = (k == 2) || (k == 9);
            PREADY = !(k >= 3 && k <= 5);
            @(negedge PCLK);
            k++;
            if (k >= 3 && k <= 6)
                chk($sformatf("t2_stable%0d", k), {PSEL, PENABLE, PWRITE, PADDR, PWDATA}, {3'b111, 32'h8, 32'h3});
        end
        start = 1'b0; PREADY = 1'b1;
        chk("t2_len", k, 27);
        chk("t2_ntx", ntx - base, 4);
        chk_tx("t2_tx1", base + 1, 1'b1, 32'h8, 32'h3);

        // PREADY stuck low on the fuse read
        PREADY = 1'b0; base = ntx;
        pulse_start();
        k = 0; acc = 0;
        while (!(done || error) && k < 300) begin
            @(negedge PCLK);
            k++;
            if (PENABLE) acc++;
        end
        chk("t3_len", k, 65);
        chk("t3_access", acc, 64);
        chk("t3_flags", {error, done, busy, PSEL, PENABLE}, 5'b10000);
        chk("t3_ntx", ntx - base, 0);

        // Restart after error; PREADY arrives on the last allowed ACCESS cycle
        base = ntx;
        pulse_start();
        chk("t4_accept", {error, busy}, 2'b01);
        k = 0;
        while (!(done || error) && k < 300) begin
            if (k == 64) PREADY = 1'b1;
            @(negedge PCLK);
            k++;
        end
        chk("t4_len", k, 87);
        chk("t4_flags", {done, error}, 2'b10);
        chk("t4_ntx", ntx - base, 4);

        // Reset during HOLD
        PREADY = 1'b1; PRDATA = 32'h0000_1234; base = ntx;
        pulse_start();
        repeat (9) @(negedge PCLK);
        chk("t5_in_hold", {busy, PSEL}, 2'b10);
        #2 PRESETn = 1'b0;
        #1 chk("t5_async_ctrl", {busy, done, error, PSEL, PENABLE, PWRITE}, 6'b0);
        chk("t5_async_bus", {PADDR, PWDATA, fuse_q}, 80'h0);
        @(negedge PCLK);
        PRESETn = 1'b1;
        repeat (30) @(negedge PCLK);
        chk("t5_idle", {busy, done, PSEL}, 3'b0);
        chk("t5_ntx", ntx - base, 3);
        base = ntx;
        pulse_start();
        chk("t5_restart", {PSEL, PWRITE, PADDR}, {2'b10, 32'hC});
        run_until(0, k);
        chk("t5_len", k, 24);
        chk("t5_flags", {done, error, fuse_q}, {2'b10, 16'h1234});
        chk("t5_ntx2", ntx - base, 4);
        chk_tx("t5_tx1", base + 1, 1'b1, 32'h8, 32'h4);
        chk_tx("t5_tx3", base + 3, 1'b1, 32'h0, 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/subsys_boot_seq.md
SUBSYS_BOOT_SEQ -- requirements
Module: subsys_boot_seq

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, APB address width.
REQ-002 Parameter DATA_WIDTH, default 32, APB data width.
REQ-003 Parameter RST_HOLD, default 16, cycles reset_subsys is held before enable (range 1..255).
REQ-004 Parameter TIMEOUT, default 64, max ACCESS-phase cycles waiting on PREADY (range 1..255).
REQ-005 PCLK  in  1  single clock, all logic on rising edge.
REQ-006 PRESETn  in  1  asynchronous active-low reset.
REQ-007 start  in  1  single-cycle pulse requesting a boot sequence.
REQ-008 busy  out  1  high while a sequence is in progress.
REQ-009 done  out  1  sticky, sequence completed OK; cleared by next accepted start.
REQ-010 error  out  1  sticky, sequence aborted on timeout; cleared by next accepted start.
REQ-011 fuse_q  out  16  fuse word captured during the sequence.
REQ-012 PADDR  out  ADDR_WIDTH  APB master address.
REQ-013 PWDATA  out  DATA_WIDTH  APB master write data.
REQ-014 PWRITE, PSEL, PENABLE  out  1 each  APB master controls.
REQ-015 PRDATA  in  DATA_WIDTH  APB read data.
REQ-016 PREADY  in  1  APB ready; slaves without PREADY tie it to 1.

Function
REQ-017 States: IDLE, SETUP, ACCESS, HOLD, DONE, ERR; op index 0..3 selects the current transfer.
REQ-018 Op table: 0 = read 0x0C (FUSE); 1 = write 0x08 (IOMUX) data {28'h0, fuse_q[3:0]}; 2 = write 0x00 (CONTROL) data 32'h2; 3 = write 0x00 data 32'h1.
REQ-019 IDLE/DONE/ERR + start=1: op=0, done=0, error=0, go to SETUP next cycle; busy=1 from that cycle.
REQ-020 start while busy is ignored, with no effect on state, op, or flags.
REQ-021 SETUP: PSEL=1, PENABLE=0, PADDR/PWRITE/PWDATA from op table; exactly 1 cycle; then ACCESS.
REQ-022 ACCESS: PSEL=1, PENABLE=1, address, data and control held stable; stay until PREADY=1.
REQ-023 ACCESS with PREADY=1 completes the transfer; op 0 captures PRDATA[15:0] into fuse_q on that edge.
REQ-024 After op 0 or op 1 completes, go to SETUP with op+1; back-to-back transfers have no idle cycle between them.
REQ-025 After op 2 completes, go to HOLD for exactly RST_HOLD cycles with PSEL=0, then SETUP op 3.
REQ-026 After op 3 completes, go to DONE: done=1, busy=0.
REQ-027 Timeout counter clears on SETUP entry and increments each ACCESS cycle with PREADY=0.
REQ-028 Reaching TIMEOUT aborts the transfer: PSEL=0 and PENABLE=0 next cycle, state ERR, error=1, busy=0, remaining ops skipped.
REQ-029 PREADY=1 on the same cycle the counter reaches TIMEOUT counts as success, not a timeout.
REQ-030 Outside SETUP/ACCESS: PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0.
REQ-031 Fuse capture is exactly 16 bits; PRDATA[DATA_WIDTH-1:16] is ignored.
REQ-032 Minimum sequence length with PREADY=1 and RST_HOLD=N: 8+N cycles from start to done, counted as 4×(SETUP+ACCESS) plus N HOLD cycles.

Reset
REQ-033 PRESETn=0 asynchronously forces IDLE, op=0, counters=0, busy=0, done=0, error=0, fuse_q=0, and all APB outputs 0.
REQ-034 Reset mid-transfer drops PSEL and PENABLE immediately; no transfer completes or resumes after reset release.
REQ-035 After PRESETn deasserts, the block waits in IDLE for start; no automatic boot.

Verification
REQ-036 PREADY=1, PRDATA=0x0000BEEF on FUSE read, start pulse -> writes 0x08←0xF, 0x00←0x2, 16 HOLD cycles, 0x00←0x1; done=1 at cycle 24; fuse_q=0xBEEF.
REQ-037 PREADY low 3 cycles in op 1 ACCESS -> PADDR/PWDATA stable for 4 ACCESS cycles; sequence completes; done=1 at cycle 27.
REQ-038 PREADY held 0 in op 0 -> error=1 after 64 ACCESS cycles, PSEL=0, no write issued, done=0.
REQ-039 start pulses at cycles 3 and 10 of an active sequence -> ignored; exactly 4 APB transfers occur.
REQ-040 PRESETn pulled low during HOLD -> all outputs 0 immediately; the op 3 write never occurs; a new start runs the full sequence from op 0.
REQ-041 Second start after error -> error cleared on acceptance; with PREADY=1 the sequence ends in done=1.
